// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake on both sides.
// SKID_EN=0 gives a single entry whose in_ready is combinational from out_ready.
// SKID_EN=1 gives a two-entry skid buffer whose in_ready comes from a flop, so
// the downstream stall signal never reaches the upstream handshake through logic.
// Outputs are driven only from state, never from in_valid/in_data.
module pipe_stage_reg #(
  parameter int                DATA_W      = 96,
  parameter int                SKID_EN     = 1,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam bit SKID = (SKID_EN != 0);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [DATA_W-1:0]   main_data_reg;
  logic [DATA_W-1:0]   skid_data_reg;
  logic                ready_reg;
  logic                ready_next;
  logic                in_fire;
  logic                out_fire;
  logic                load_main;
  logic                load_skid;
  logic                skid_to_main;

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = out_valid ? main_data_reg : BUBBLE_DATA;
  assign occupancy = state_reg;

  // ready_reg is 0 in reset and becomes 1 on the first edge after release.
  // In skid mode it also tracks "skid slot free" for the state being entered.
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = ready_reg;
    end else begin : g_single_ready
      assign in_ready = ready_reg & (~out_valid | out_ready);
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and data-steering decisions; flush overrides every transfer.
  always_comb begin
    state_next   = state_reg;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          // Without a skid slot, an accepted input always coincides with
          // the held entry leaving, so the entry is simply replaced.
          if (in_fire && (out_fire || !SKID)) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_next   = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
    ready_next = SKID ? (state_next != TWO) : 1'b1;
  end

  // State and ready flop; reset forces EMPTY and not-ready without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
    end
  end

  // Payload storage: main entry feeds out_data, skid entry catches overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data_reg <= BUBBLE_DATA;
      skid_data_reg <= BUBBLE_DATA;
    end else begin
      if (load_main) begin
        main_data_reg <= in_data;
      end else if (skid_to_main) begin
        main_data_reg <= skid_data_reg;
      end
      if (load_skid) begin
        skid_data_reg <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (index 0) and a single-entry
// instance (index 1) run side by side, each against a small FIFO model.
module tb_pipe_stage_reg;

  localparam int          W   = 32;
  localparam logic [W-1:0] BUB = 32'h00000013;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush     [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_data  [2];
  logic [1:0]   occupancy [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .SKID_EN(1), .BUBBLE_DATA(BUB)) dut_skid (
    .clk(clk), .reset_n(reset_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occupancy[0])
  );

  pipe_stage_reg #(.DATA_W(W), .SKID_EN(0), .BUBBLE_DATA(BUB)) dut_single (
    .clk(clk), .reset_n(reset_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occupancy[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference model: held payloads in arrival order, oldest at slot 0.
  logic [W-1:0] held [2][2];
  int           cnt  [2];
  bit           started;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_ready(input int d);
    if (!started) return 1'b0;
    if (d == 0) return (cnt[0] < 2);
    return (cnt[1] == 0) || out_ready[1];
  endfunction

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_out_valid", d), {31'b0, out_valid[d]}, {31'b0, cnt[d] > 0});
      check($sformatf("d%0d_out_data", d), out_data[d], (cnt[d] > 0) ? held[d][0] : BUB);
      check($sformatf("d%0d_occupancy", d), {30'b0, occupancy[d]}, W'(cnt[d]));
      check($sformatf("d%0d_in_ready", d), {31'b0, in_ready[d]}, {31'b0, exp_ready(d)});
    end
  endtask

  task automatic drive(input int d, input logic fl, input logic iv, input logic [W-1:0] id,
                       input logic ordy);
    flush[d]     = fl;
    in_valid[d]  = iv;
    in_data[d]   = id;
    out_ready[d] = ordy;
  endtask

  task automatic model_clear();
    cnt[0]  = 0;
    cnt[1]  = 0;
    started = 1'b0;
  endtask

  // One clock: inputs already driven after a negedge; check, then advance the model.
  task automatic cycle();
    bit fin  [2];
    bit fout [2];
    #1;
    check_outputs();
    for (int d = 0; d < 2; d++) begin
      fin[d]  = in_valid[d] && exp_ready(d);
      fout[d] = (cnt[d] > 0) && out_ready[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (fout[d]) $display("d%0d transfer out %h", d, held[d][0]);
      if (flush[d]) begin
        cnt[d] = 0;
      end else begin
        if (fout[d]) begin
          held[d][0] = held[d][1];
          cnt[d]--;
        end
        if (fin[d]) begin
          held[d][cnt[d]] = in_data[d];
          cnt[d]++;
        end
      end
    end
    if (reset_n) started = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_both(input logic ordy);
    drive(0, 1'b0, 1'b0, '0, ordy);
    drive(1, 1'b0, 1'b0, '0, ordy);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_both(1'b0);
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    reset_n = 1'b1;
    #1;
    check_outputs();

    // Streaming A,B,C with downstream always ready.
    drive(0, 1'b0, 1'b1, 32'hAAAA0001, 1'b1);
    drive(1, 1'b0, 1'b1, 32'hAAAA0001, 1'b1);
    cycle();
    drive(0, 1'b0, 1'b1, 32'hBBBB0002, 1'b1);
    drive(1, 1'b0, 1'b1, 32'hBBBB0002, 1'b1);
    cycle();
    drive(0, 1'b0, 1'b1, 32'hCCCC0003, 1'b1);
    drive(1, 1'b0, 1'b1, 32'hCCCC0003, 1'b1);
    cycle();
    idle_both(1'b1);
    cycle();
    cycle();

    // Stall: A,B into skid, C presented while full, then drain.
    drive(0, 1'b0, 1'b1, 32'h0000000A, 1'b0);
    drive(1, 1'b0, 1'b1, 32'h0000000A, 1'b0);
    cycle();
    drive(0, 1'b0, 1'b1, 32'h0000000B, 1'b0);
    drive(1, 1'b0, 1'b1, 32'h0000000B, 1'b0);
    cycle();
    drive(0, 1'b0, 1'b1, 32'h0000000C, 1'b0);
    drive(1, 1'b0, 1'b1, 32'h0000000C, 1'b1);
    cycle();
    idle_both(1'b1);
    repeat (3) cycle();

    // Flush while full with a payload presented in the same cycle.
    drive(0, 1'b0, 1'b1, 32'h11110001, 1'b0);
    drive(1, 1'b0, 1'b1, 32'h11110001, 1'b0);
    cycle();
    drive(0, 1'b0, 1'b1, 32'h11110002, 1'b0);
    drive(1, 1'b0, 1'b1, 32'h11110002, 1'b0);
    cycle();
    drive(0, 1'b1, 1'b1, 32'h1111000C, 1'b1);
    drive(1, 1'b1, 1'b1, 32'h1111000C, 1'b1);
    cycle();
    idle_both(1'b1);
    repeat (2) cycle();

    // Reset between edges with one entry held.
    drive(0, 1'b0, 1'b1, 32'h55550001, 1'b0);
    drive(1, 1'b0, 1'b1, 32'h55550001, 1'b0);
    cycle();
    idle_both(1'b0);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    idle_both(1'b1);
    cycle();
    cycle();

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 800; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom(),
              ($urandom_range(0, 2) != 0));
      end
      cycle();
    end

    idle_both(1'b1);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning payload width in bits (96 = PC+4, PC, instruction).
REQ-002 The block SHALL have parameter SKID_EN, default 1, meaning 0 = single-entry register, 1 = two-entry skid buffer.
REQ-003 The block SHALL have parameter BUBBLE_DATA, default {DATA_W{1'b0}}, meaning payload driven on OUT_DATA whenever OUT_VALID=0.
REQ-004 The block SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port FLUSH  input  1  synchronous kill of all held and incoming entries.
REQ-007 The block SHALL have port IN_VALID  input  1  upstream payload valid.
REQ-008 The block SHALL have port IN_READY  output  1  block accepts payload this cycle.
REQ-009 The block SHALL have port IN_DATA  input  DATA_W  upstream payload.
REQ-010 The block SHALL have port OUT_VALID  output  1  downstream payload valid.
REQ-011 The block SHALL have port OUT_READY  input  1  downstream accepts payload (deasserted = stall).
REQ-012 The block SHALL have port OUT_DATA  output  DATA_W  downstream payload.
REQ-013 The block SHALL have port OCCUPANCY  output  2  number of valid entries held (0..1 if SKID_EN=0, 0..2 if SKID_EN=1).

Function
REQ-014 An input transfer SHALL occur on a rising edge when IN_VALID=1 and IN_READY=1; an output transfer SHALL occur when OUT_VALID=1 and OUT_READY=1.
REQ-015 Payloads SHALL leave in arrival order; none SHALL be duplicated or dropped except by FLUSH.
REQ-016 Latency from input transfer to OUT_VALID=1 SHALL be exactly 1 cycle when the block is empty.
REQ-017 While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_VALID SHALL hold stable.
REQ-018 OUT_DATA SHALL equal BUBBLE_DATA whenever OUT_VALID=0.
REQ-019 There SHALL be no combinational path from IN_VALID/IN_DATA to OUT_VALID/OUT_DATA.
REQ-020 SKID_EN=0: one entry; IN_READY = (!OUT_VALID | OUT_READY), combinational; simultaneous in/out transfer SHALL replace the entry (throughput 1/cycle).
REQ-021 SKID_EN=1: IN_READY SHALL be a registered signal equal to (skid entry empty), with no combinational path from OUT_READY to IN_READY.
REQ-022 SKID_EN=1 states: EMPTY (occ 0), ONE (occ 1, main entry valid), TWO (occ 2, main and skid valid).
REQ-023 EMPTY -> ONE on input transfer; otherwise stay.
REQ-024 ONE: input and output transfer -> ONE (main reloaded); input only -> TWO (payload into skid); output only -> EMPTY; neither -> stay.
REQ-025 TWO: output transfer -> ONE (skid moves to main, IN_READY rises next cycle); no input accepted in TWO.
REQ-026 OCCUPANCY SHALL reflect the state after the edge: 0, 1, 2 for EMPTY, ONE, TWO.
REQ-027 FLUSH=1 SHALL have priority over all transfers: next cycle occupancy 0, OUT_VALID=0, OUT_DATA=BUBBLE_DATA, IN_READY=1; payload presented during the FLUSH cycle SHALL be discarded.
REQ-028 An output transfer in the FLUSH cycle SHALL still count as completed for downstream; only the held copies are cleared.

Reset
REQ-029 RESET_N=0 SHALL immediately, without a clock edge, force OUT_VALID=0, OUT_DATA=BUBBLE_DATA, OCCUPANCY=0, IN_READY=0, with state EMPTY.
REQ-030 IN_READY SHALL be 1 from the first rising edge after RESET_N deasserts (both modes).
REQ-031 Reset asserted mid-transfer SHALL discard all entries; no payload held before reset SHALL appear after it.

Verification
REQ-032 SKID_EN=1: stream A,B,C with OUT_READY=1 -> OUT_DATA A,B,C on consecutive cycles, each 1 cycle after input, OCCUPANCY 1 throughout.
REQ-033 SKID_EN=1: send A,B with OUT_READY=0 -> OCCUPANCY 2, IN_READY=0, OUT_DATA=A held; raise OUT_READY -> A then B delivered, then OCCUPANCY 0.
REQ-034 FLUSH with OCCUPANCY 2 and IN_VALID=1 (payload C) -> next cycle OUT_VALID=0, OUT_DATA=BUBBLE_DATA, IN_READY=1; C never appears.
REQ-035 SKID_EN=0: OUT_READY=0 with one entry -> IN_READY=0 same cycle; OUT_READY=1 with IN_VALID=1 -> entry replaced in one cycle.
REQ-036 RESET_N pulled low between edges while OCCUPANCY=1 -> OUT_VALID=0 and OUT_DATA=BUBBLE_DATA before next edge; IN_READY=1 one edge after release.
REQ-037 DATA_W=32, BUBBLE_DATA=32'h00000013 -> OUT_DATA=32'h00000013 whenever OUT_VALID=0, including after reset and FLUSH.
